// File: rtl/shift_sequencer_if.sv
// Handshake bundle between a command source/result consumer and the shift sequencer.
// Both channels use valid/ready: a transfer happens on a rising clk edge where
// valid and ready are both high; the sender holds its payload stable while valid
// is high and ready is low.
interface shift_sequencer_if #(
    parameter int WIDTH = 4,
    parameter int AMT_W = 2
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_data;
    logic [AMT_W-1:0] cmd_amt;
    logic             cmd_dir;
    logic [1:0]       cmd_mode;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             busy;
    logic [7:0]       op_count;

    // Command source / result consumer side.
    modport master (
        output cmd_valid, cmd_data, cmd_amt, cmd_dir, cmd_mode, res_ready,
        input  cmd_ready, res_valid, res_data, busy, op_count
    );

    // Sequencer side.
    modport slave (
        input  cmd_valid, cmd_data, cmd_amt, cmd_dir, cmd_mode, res_ready,
        output cmd_ready, res_valid, res_data, busy, op_count
    );
endinterface

// File: rtl/shift_sequencer.sv
// Shift sequencer: accepts one shift command, performs it one bit position per
// clock, then presents the result until the consumer takes it.
// Optional feature macro SHIFT_SEQUENCER_ARITH_EN: when defined, mode 2'b10 with
// dir = 1 shifts right with sign fill; when undefined, mode 2'b10 is logical.
module shift_sequencer #(
    parameter int WIDTH = 4,
    parameter int AMT_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    shift_sequencer_if.slave  bus,
    output logic [1:0]        fsm_state
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] work;
    logic [WIDTH-1:0] step;
    logic [AMT_W-1:0] cnt;
    logic             dir;
    logic [1:0]       mode;
    logic [7:0]       count;
    logic             accept;
    logic             release_res;

    assign fsm_state    = state;
    assign bus.res_data = work;
    assign bus.op_count = count;
    assign accept       = (state == IDLE) && bus.cmd_valid;
    assign release_res  = (state == DONE) && bus.res_ready;

    // State register; reset drops any in-flight command immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs, all decoded from the current state.
    always_comb begin
        state_next    = state;
        bus.cmd_ready = 1'b0;
        bus.res_valid = 1'b0;
        bus.busy      = 1'b0;
        case (state)
            IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    state_next = (bus.cmd_amt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                bus.busy = 1'b1;
                if (cnt == AMT_W'(1)) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                bus.busy      = 1'b1;
                bus.res_valid = 1'b1;
                if (bus.res_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // One-position step of the working register for the latched dir/mode.
    always_comb begin
        step = dir ? {1'b0, work[WIDTH-1:1]} : {work[WIDTH-2:0], 1'b0};
        if (mode == 2'b01) begin
            step = dir ? {work[0], work[WIDTH-1:1]} : {work[WIDTH-2:0], work[WIDTH-1]};
        end
`ifdef SHIFT_SEQUENCER_ARITH_EN
        else if ((mode == 2'b10) && dir) begin
            step = {work[WIDTH-1], work[WIDTH-1:1]};
        end
`endif
    end

    // Datapath: latch on accept, step while shifting, count released results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            work  <= '0;
            cnt   <= '0;
            dir   <= 1'b0;
            mode  <= 2'b00;
            count <= 8'd0;
        end else begin
            if (accept) begin
                work <= bus.cmd_data;
                cnt  <= bus.cmd_amt;
                dir  <= bus.cmd_dir;
                mode <= bus.cmd_mode;
            end else if (state == SHIFT) begin
                work <= step;
                cnt  <= cnt - AMT_W'(1);
            end
            if (release_res) begin
                count <= count + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_shift_sequencer.sv
// Bench for shift_sequencer: inputs are driven and outputs sampled on the
// falling edge, so every check sees settled values between rising edges.
module tb_shift_sequencer;
    logic       clk;
    logic       rst;
    logic [1:0] fsm_state;

    int         n_checks;
    int         n_fail;
    int         model_cnt;
    logic [3:0] exp_q[$];

    shift_sequencer_if #(.WIDTH(4), .AMT_W(2)) bus ();

    shift_sequencer #(.WIDTH(4), .AMT_W(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .fsm_state (fsm_state)
    );

    // Clock and reset block.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Whole-operation reference: shift by amt positions in one go.
    function automatic logic [3:0] model_shift(input logic [3:0] d, input int amt,
                                               input logic dir, input logic [1:0] mode);
        int  v;
        int  r;
        int  sv;
        bit  arith;
        v = int'(d);
`ifdef SHIFT_SEQUENCER_ARITH_EN
        arith = (mode == 2'b10) && dir;
`else
        arith = 1'b0;
`endif
        if (mode == 2'b01) begin
            if (!dir) r = (v << amt) | (v >> (4 - amt));
            else      r = (v >> amt) | (v << (4 - amt));
        end else if (arith) begin
            sv = (v >= 8) ? v - 16 : v;
            r  = sv >>> amt;
        end else begin
            if (!dir) r = v << amt;
            else      r = v >> amt;
        end
        return 4'(r & 15);
    endfunction

    task automatic check_reset_values(input string name);
        n_checks++;
        if (bus.cmd_ready !== 1'b1 || bus.res_valid !== 1'b0 || bus.res_data !== 4'd0 ||
            bus.busy !== 1'b0 || bus.op_count !== 8'd0) begin
            n_fail++;
            $display("FAIL %s: cmd_ready=%b res_valid=%b res_data=%b busy=%b op_count=%0d, required 1 0 0000 0 0",
                     name, bus.cmd_ready, bus.res_valid, bus.res_data, bus.busy, bus.op_count);
        end
    endtask

    // Driver: present a command at the current falling edge, follow it to the
    // result, optionally stall the result for hold cycles, then release it.
    // Returns at the falling edge after the result handshake.
    task automatic run_cmd(input logic [3:0] d, input int amt, input logic dir,
                           input logic [1:0] mode, input int hold, output logic [3:0] got);
        int         k;
        logic [3:0] exp;
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = d;
        bus.cmd_amt   = 2'(amt);
        bus.cmd_dir   = dir;
        bus.cmd_mode  = mode;
        bus.res_ready = (hold == 0);
        n_checks++;
        if (bus.cmd_ready !== 1'b1 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL accept_idle: cmd_ready=%b busy=%b, required 1 0", bus.cmd_ready, bus.busy);
        end
        exp_q.push_back(model_shift(d, amt, dir, mode));
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = 4'($urandom_range(0, 15));
        bus.cmd_amt   = 2'($urandom_range(0, 3));
        bus.cmd_dir   = 1'($urandom_range(0, 1));
        bus.cmd_mode  = 2'($urandom_range(0, 3));
        k = 0;
        while (bus.res_valid !== 1'b1 && k < 8) begin
            n_checks++;
            if (bus.res_data !== model_shift(d, k, dir, mode) || bus.busy !== 1'b1 || bus.cmd_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL shift_step%0d: res_data=%b busy=%b cmd_ready=%b, required %b 1 0",
                         k, bus.res_data, bus.busy, bus.cmd_ready, model_shift(d, k, dir, mode));
            end
            @(negedge clk);
            k++;
        end
        n_checks++;
        if (k != amt) begin
            n_fail++;
            $display("FAIL latency: res_valid after %0d edges, required %0d", k, amt);
        end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 4'hx;
        got = bus.res_data;
        n_checks++;
        if (bus.res_data !== exp || bus.busy !== 1'b1 || bus.cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL result: res_data=%b busy=%b cmd_ready=%b, required %b 1 0",
                     bus.res_data, bus.busy, bus.cmd_ready, exp);
        end
        for (int i = 0; i < hold; i++) begin
            bus.cmd_valid = 1'b1;
            bus.cmd_data  = 4'($urandom_range(0, 15));
            bus.cmd_amt   = 2'($urandom_range(0, 3));
            @(negedge clk);
            n_checks++;
            if (bus.res_valid !== 1'b1 || bus.res_data !== exp || bus.busy !== 1'b1 || bus.cmd_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL backpressure%0d: res_valid=%b res_data=%b busy=%b cmd_ready=%b, required 1 %b 1 0",
                         i, bus.res_valid, bus.res_data, bus.busy, bus.cmd_ready, exp);
            end
        end
        bus.cmd_valid = 1'b0;
        bus.res_ready = 1'b1;
        @(negedge clk);
        model_cnt = (model_cnt + 1) % 256;
        n_checks++;
        if (bus.cmd_ready !== 1'b1 || bus.res_valid !== 1'b0 || bus.busy !== 1'b0 ||
            bus.res_data !== exp || bus.op_count !== 8'(model_cnt)) begin
            n_fail++;
            $display("FAIL release: cmd_ready=%b res_valid=%b busy=%b res_data=%b op_count=%0d, required 1 0 0 %b %0d",
                     bus.cmd_ready, bus.res_valid, bus.busy, bus.res_data, bus.op_count, exp, model_cnt);
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst           = 1'b1;
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = 4'b1010;
        bus.cmd_amt   = 2'd0;
        bus.res_ready = 1'b1;
        #1;
        check_reset_values("reset_async");
        repeat (2) @(negedge clk);
        check_reset_values("reset_held");
        rst           = 1'b0;
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        check_reset_values("reset_release");
        model_cnt = 0;
        exp_q.delete();
    endtask

    task automatic test_logical_left();
        logic [3:0] got;
        run_cmd(4'b1011, 1, 1'b0, 2'b00, 0, got);
        n_checks++;
        if (got !== 4'b0110 || bus.op_count !== 8'd1) begin
            n_fail++;
            $display("FAIL logical_left: got=%b op_count=%0d, required 0110 1", got, bus.op_count);
        end
    endtask

    task automatic test_rotate_right();
        logic [3:0] got;
        run_cmd(4'b1011, 3, 1'b1, 2'b01, 0, got);
        n_checks++;
        if (got !== 4'b0111) begin
            n_fail++;
            $display("FAIL rotate_right: got=%b, required 0111", got);
        end
    endtask

    task automatic test_zero_amount();
        logic [3:0] got;
        run_cmd(4'b1001, 0, 1'b0, 2'b00, 0, got);
        n_checks++;
        if (got !== 4'b1001) begin
            n_fail++;
            $display("FAIL zero_amount: got=%b, required 1001", got);
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] got;
        run_cmd(4'b0110, 2, 1'b1, 2'b01, 5, got);
        n_checks++;
        if (got !== 4'b1001) begin
            n_fail++;
            $display("FAIL backpressure_result: got=%b, required 1001", got);
        end
    endtask

    task automatic test_reset_mid_shift();
        logic [3:0] got;
        bus.cmd_valid = 1'b1;
        bus.cmd_data  = 4'b1111;
        bus.cmd_amt   = 2'd3;
        bus.cmd_dir   = 1'b0;
        bus.cmd_mode  = 2'b00;
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        model_cnt = 0;
        exp_q.delete();
        check_reset_values("reset_mid_shift");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (bus.res_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL discarded_cmd%0d: res_valid=%b cmd_ready=%b, required 0 1",
                         i, bus.res_valid, bus.cmd_ready);
            end
        end
        run_cmd(4'b0001, 2, 1'b0, 2'b00, 0, got);
        n_checks++;
        if (got !== 4'b0100 || bus.op_count !== 8'd1) begin
            n_fail++;
            $display("FAIL post_reset_cmd: got=%b op_count=%0d, required 0100 1", got, bus.op_count);
        end
    endtask

    task automatic test_arith();
        logic [3:0] got;
        logic [3:0] req;
`ifdef SHIFT_SEQUENCER_ARITH_EN
        req = 4'b1110;
`else
        req = 4'b0010;
`endif
        run_cmd(4'b1000, 2, 1'b1, 2'b10, 0, got);
        n_checks++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL arith_right: got=%b, required %b", got, req);
        end
        run_cmd(4'b1001, 1, 1'b0, 2'b10, 0, got);
        n_checks++;
        if (got !== 4'b0010) begin
            n_fail++;
            $display("FAIL arith_left: got=%b, required 0010", got);
        end
    endtask

    task automatic test_back_to_back_random();
        logic [3:0] got;
        for (int i = 0; i < 40; i++) begin
            run_cmd(4'($urandom_range(0, 15)), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                    2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0, got);
        end
    endtask

    task automatic test_wrap();
        logic [3:0] got;
        test_reset();
        for (int i = 0; i < 256; i++) begin
            run_cmd(4'($urandom_range(0, 15)), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
                    2'($urandom_range(0, 3)), 0, got);
            if (i == 254) begin
                n_checks++;
                if (bus.op_count !== 8'd255) begin
                    n_fail++;
                    $display("FAIL count_255: op_count=%0d, required 255", bus.op_count);
                end
            end
        end
        n_checks++;
        if (bus.op_count !== 8'd0) begin
            n_fail++;
            $display("FAIL count_wrap: op_count=%0d, required 0", bus.op_count);
        end
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        model_cnt     = 0;
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_data  = 4'd0;
        bus.cmd_amt   = 2'd0;
        bus.cmd_dir   = 1'b0;
        bus.cmd_mode  = 2'b00;
        bus.res_ready = 1'b0;
        test_reset();
        test_logical_left();
        test_rotate_right();
        test_zero_amount();
        test_backpressure();
        test_reset_mid_shift();
        test_arith();
        test_back_to_back_random();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Sequencing controller for the team's 4-bit shifter datapath. It accepts one shift command at a time over a valid/ready handshake and executes it as a series of single-position shift steps, one step per clock. It holds the result behind a valid/ready output handshake and counts completed operations. It sits between a command source (testbench or upstream control) and the combinational shift/logic datapath.

## Interface
- WIDTH, 4: data width in bits. Only 4 is supported.
- AMT_W, 2: shift-amount width. Legal amounts are 0..WIDTH-1.
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  controller can accept a command; equals (state == IDLE).
- cmd_data  input  WIDTH  operand.
- cmd_amt  input  AMT_W  number of positions to shift.
- cmd_dir  input  1  direction: 0 = left, 1 = right.
- cmd_mode  input  2  mode: 00 logical, 01 rotate, 10 arithmetic (see Configuration), 11 treated as logical.
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts the result.
- res_data  output  WIDTH  shifted result.
- busy  output  1  high in SHIFT or DONE.
- op_count  output  8  completed-operation counter; wraps.

## Operation
- State machine states: IDLE, SHIFT, DONE.
  - IDLE: cmd_ready = 1. On cmd_valid && cmd_ready, latch cmd_data into the working register, cmd_amt into the step counter, and latch dir and mode.
    - If amt != 0, go to SHIFT.
    - If amt == 0, go to DONE.
  - SHIFT: each edge, shift the working register one position and decrement the counter. The edge on which counter == 1 performs the last step and moves to DONE.
  - DONE: res_valid = 1 and res_data = working register. On res_valid && res_ready: go to IDLE and increment op_count.
- Single-step rules:
  - Logical left: {r[2:0], 0}.
  - Logical right: {0, r[3:1]}.
  - Rotate left: {r[2:0], r[3]}.
  - Rotate right: {r[0], r[3:1]}.
  - Arithmetic right: {r[3], r[3:1]}.
  - Arithmetic left is identical to logical left.
- Command inputs are ignored outside IDLE. Changes to cmd_* during SHIFT or DONE have no effect.
- res_data holds the last result after leaving DONE. It changes only while in SHIFT, or when a new command is accepted.
- op_count wraps from 255 to 0.

## Timing
- Reset values while rst is high and immediately after release:
  - state IDLE, cmd_ready 1, res_valid 0, res_data 0, busy 0, op_count 0.
  - Handshakes are not honoured while rst is high.
- Accept edge t0 with amt N: res_valid goes high after edge t0+N.
  - N = 0 gives res_valid in the cycle immediately after acceptance.
  - N = 3 gives three SHIFT cycles.
- Result handshake completes on edge tr. cmd_ready is high in the next cycle. The next accept is at the earliest edge tr+1.
  - Maximum throughput is one command per N+2 cycles.
- Backpressure: while res_ready = 0 in DONE, res_valid, res_data and busy stay constant indefinitely.
- Reset asserted mid-operation (SHIFT or DONE) returns to IDLE immediately (asynchronously).
  - The in-flight command is discarded and op_count is cleared.
  - No res_valid is produced for the discarded command.
- cmd_ready and res_valid are never high in the same cycle.

## Configuration
- SHIFT_SEQUENCER_ARITH_EN defined: cmd_mode 10 performs an arithmetic right shift (sign fill) when dir = 1. With dir = 0 it performs a logical left shift.
- Not defined: cmd_mode 10 behaves exactly as 00 (logical). No sign-fill logic is synthesised.

## Test plan
- Logical left: data 1011, amt 1, dir 0, mode 00, res_ready 1. Require res_valid one edge after accept, res_data 0110, op_count 1.
- Rotate right: data 1011, amt 3, dir 1, mode 01. Require three SHIFT cycles with intermediate values 1101, 1110, then res_data 0111.
- Zero amount: data 1001, amt 0. Require res_valid in the cycle after accept, res_data 1001, busy high for exactly that cycle when res_ready = 1.
- Backpressure: hold res_ready = 0 for 5 cycles in DONE. Require res_data stable, cmd_ready 0, and a new cmd_valid ignored. After res_ready = 1, require IDLE next cycle.
- Reset mid-shift: data 1111, amt 3, assert rst during the second SHIFT cycle. Require all outputs at reset values immediately and no result. A post-reset command 0001, amt 2, left logical must give 0100.
- Arithmetic mode: data 1000, amt 2, dir 1, mode 10. With the macro, require 1110. Without the macro, require 0010. Also run 256 operations and require op_count to wrap to 0.
